ysyx_25030093_mem_arbiter: RTL and testbench

//  Shares one memory port between the IFU fetch port and the LSU data port of the ysyx_25030093 core.

---
 rtl/ysyx_25030093_mem_arbiter_pkg.sv | 30 +++
 rtl/ysyx_25030093_mem_arbiter_if.sv | 50 +++++
 rtl/ysyx_25030093_rr_pick.sv | 24 ++
 rtl/ysyx_25030093_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_ysyx_25030093_mem_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25030093_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// Holds the FSM state and owner encodings, the access-size codes and the latched request record.
// No logic; imported by the interface, the picker and the top.
package ysyx_25030093_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Request fields captured at grant and replayed downstream while busy.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Bundle of the IFU, LSU and downstream memory signals around the arbiter.
// slave = the arbiter's view; master = the core/memory environment around it.
// Handshake is request-held-until-response-pulse on both upstream ports.
interface ysyx_25030093_mem_arbiter_if;
  import ysyx_25030093_arb_pkg::*;

  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  logic        err_timeout;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_respValid, mem_rdata,
    output ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output err_timeout
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_respValid, mem_rdata,
    input  ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  err_timeout
  );

endinterface

// File: rtl/ysyx_25030093_rr_pick.sv
// Two-way round-robin picker: on a tie the side that did not win last time is chosen.
// Purely combinational, zero latency.
// No backpressure of its own; the caller decides when the pick is consumed.
module ysyx_25030093_rr_pick
  import ysyx_25030093_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic       gnt_valid,
  output owner_t     gnt_id
);

  // Bit 0 is the IFU, bit 1 the LSU; a tie alternates against the previous winner.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWN_IFU;
    if (req[0] && req[1]) begin
      gnt_id = (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (req[1]) begin
      gnt_id = OWN_LSU;
    end
  end

endmodule

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU accesses, with a response timeout.
// Latency: request in cycle t -> mem_reqValid from t+1; response routed back in the same cycle.
// Backpressure: the loser's request is simply held off until the arbiter returns to IDLE.
module ysyx_25030093_mem_arbiter
  import ysyx_25030093_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  ysyx_25030093_mem_arbiter_if.slave   bus
);

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  owner_t           last_grant;
  mem_req_t         req_q;
  mem_req_t         grant_req;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic             gnt_valid;
  owner_t           gnt_id;
  logic             grant;
  logic             resp_hit;
  logic             to_hit;

  ysyx_25030093_rr_pick u_pick (
    .req       ({bus.lsu_reqValid, bus.ifu_reqValid}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Request record for whichever side the picker chose; IFU is always a 4-byte read.
  always_comb begin
    grant_req = '0;
    if (gnt_id == OWN_IFU) begin
      grant_req.addr = bus.ifu_addr;
      grant_req.size = SZ_W;
    end else begin
      grant_req.addr  = bus.lsu_addr;
      grant_req.size  = bus.lsu_size;
      grant_req.wen   = bus.lsu_wen;
      grant_req.wdata = bus.lsu_wdata;
      grant_req.wmask = bus.lsu_wmask;
    end
  end

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus response routing; a real response beats a timeout in the same cycle.
  always_comb begin
    state_nxt         = state;
    grant             = 1'b0;
    resp_hit          = 1'b0;
    to_hit            = 1'b0;
    bus.ifu_respValid = 1'b0;
    bus.ifu_rdata     = '0;
    bus.lsu_respValid = 1'b0;
    bus.lsu_rdata     = '0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant     = 1'b1;
          state_nxt = (gnt_id == OWN_IFU) ? BUSY_IFU : BUSY_LSU;
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        if (bus.mem_respValid) begin
          resp_hit  = 1'b1;
          state_nxt = IDLE;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state == BUSY_IFU) begin
      bus.ifu_respValid = resp_hit | to_hit;
      bus.ifu_rdata     = resp_hit ? bus.mem_rdata : '0;
    end
    if (state == BUSY_LSU) begin
      bus.lsu_respValid = resp_hit | to_hit;
      bus.lsu_rdata     = resp_hit ? bus.mem_rdata : '0;
    end
  end

  // Grant latch, round-robin history, timeout counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q      <= '0;
      last_grant <= OWN_LSU;
      cnt        <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant) begin
        req_q      <= grant_req;
        last_grant <= gnt_id;
        cnt        <= '0;
      end else if ((state != IDLE) && !bus.mem_respValid) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (to_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_reqValid = (state != IDLE);
  assign bus.mem_addr     = req_q.addr;
  assign bus.mem_size     = req_q.size;
  assign bus.mem_wen      = req_q.wen;
  assign bus.mem_wdata    = req_q.wdata;
  assign bus.mem_wmask    = req_q.wmask;
  // Flag is visible in the timeout pulse cycle itself and held afterwards.
  assign bus.err_timeout  = err_q | to_hit;

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Directed bench for the memory arbiter: a per-cycle vector table plus timeout and reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Timeout is shortened to 8 cycles so the timeout path is reachable quickly.
module tb_ysyx_25030093_mem_arbiter;
  import ysyx_25030093_arb_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        lsu_req;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        mem_resp;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        ifu_rv;
    logic [31:0] ifu_rdata;
    logic        lsu_rv;
    logic [31:0] lsu_rdata;
    logic        err;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
    logic m;   // 1: also compare latched mem_* fields
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tab[$];

  ysyx_25030093_mem_arbiter_if bus ();

  ysyx_25030093_mem_arbiter #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic drive(input in_t x);
    reset             = x.rst;
    bus.ifu_reqValid  = x.ifu_req;
    bus.ifu_addr      = x.ifu_addr;
    bus.lsu_reqValid  = x.lsu_req;
    bus.lsu_addr      = x.lsu_addr;
    bus.lsu_size      = x.lsu_size;
    bus.lsu_wen       = x.lsu_wen;
    bus.lsu_wdata     = x.lsu_wdata;
    bus.lsu_wmask     = x.lsu_wmask;
    bus.mem_respValid = x.mem_resp;
    bus.mem_rdata     = x.mem_rdata;
  endtask

  function automatic out_t sample();
    out_t o;
    o.mem_req   = bus.mem_reqValid;
    o.mem_addr  = bus.mem_addr;
    o.mem_size  = bus.mem_size;
    o.mem_wen   = bus.mem_wen;
    o.mem_wdata = bus.mem_wdata;
    o.mem_wmask = bus.mem_wmask;
    o.ifu_rv    = bus.ifu_respValid;
    o.ifu_rdata = bus.ifu_rdata;
    o.lsu_rv    = bus.lsu_respValid;
    o.lsu_rdata = bus.lsu_rdata;
    o.err       = bus.err_timeout;
    return o;
  endfunction

  task automatic push(input in_t i, input out_t o, input logic m);
    vec_t v;
    v.i = i;
    v.o = o;
    v.m = m;
    tab.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input in_t x);
    @(negedge clock);
    drive(x);
    #1;
  endtask

  in_t  i_ifu0, i_ifu0_r, i_st, i_st_r, i_both1, i_both1_r, i_both2, i_both2_r, i_both2_r3;
  in_t  i_ld, i_rq;
  out_t a, e;

  initial begin
    // Cycle inputs for the table (fields: rst ifu_req ifu_addr lsu_req lsu_addr size wen wdata wmask mem_resp mem_rdata).
    i_ifu0     = '{1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0};
    i_ifu0_r   = i_ifu0;     i_ifu0_r.mem_resp = 1'b1;  i_ifu0_r.mem_rdata = 32'h0000_0413;
    i_st       = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 2'd1, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0};
    i_st_r     = i_st;       i_st_r.mem_resp = 1'b1;    i_st_r.mem_rdata = 32'h0000_00AA;
    i_both1    = '{1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0200, 2'd2, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    i_both1_r  = i_both1;    i_both1_r.mem_resp = 1'b1; i_both1_r.mem_rdata = 32'h1111_1111;
    i_both2    = i_both1;    i_both2.ifu_addr = 32'h8000_0008;
    i_both2_r  = i_both2;    i_both2_r.mem_resp = 1'b1; i_both2_r.mem_rdata = 32'h2222_2222;
    i_both2_r3 = i_both2;    i_both2_r3.mem_resp = 1'b1; i_both2_r3.mem_rdata = 32'h3333_3333;

    // Reset state, then IFU fetch answered on its 3rd busy cycle, then a stray response in IDLE.
    push('{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0}, '0, 1'b1);
    push(i_ifu0, '0, 1'b1);
    push(i_ifu0, '{1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}, 1'b1);
    push(i_ifu0, '{1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}, 1'b1);
    push(i_ifu0_r, '{1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0000_0413, 1'b0, 32'h0, 1'b0}, 1'b1);
    push('{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0000_1234}, '0, 1'b0);
    // LSU halfword store; response is a single-cycle pulse.
    push(i_st, '0, 1'b0);
    push(i_st, '{1'b1, 32'h8000_0100, 2'd1, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}, 1'b1);
    push(i_st_r, '{1'b1, 32'h8000_0100, 2'd1, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0, 1'b1, 32'h0000_00AA, 1'b0}, 1'b1);
    push('0, '0, 1'b0);
    // Reset, then tie -> IFU; IFU re-requests in its response cycle -> LSU next; tie again -> IFU.
    push('{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0}, '0, 1'b0);
    push(i_both1, '0, 1'b1);
    push(i_both1, '{1'b1, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}, 1'b1);
    push(i_both1_r, '{1'b1, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 4'h0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0}, 1'b1);
    push(i_both2, '0, 1'b0);
    push(i_both2, '{1'b1, 32'h8000_0200, 2'd2, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}, 1'b1);
    push(i_both2_r, '{1'b1, 32'h8000_0200, 2'd2, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b1, 32'h2222_2222, 1'b0}, 1'b1);
    push(i_both2, '0, 1'b0);
    push(i_both2, '{1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}, 1'b1);
    push(i_both2_r3, '{1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'h0, 4'h0, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b0}, 1'b1);
    push('0, '0, 1'b0);

    drive('{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0});
    repeat (2) @(posedge clock);

    foreach (tab[k]) begin
      step(tab[k].i);
      a = sample();
      e = tab[k].o;
      if (!tab[k].m) begin
        a.mem_addr = '0; a.mem_size = '0; a.mem_wen = '0; a.mem_wdata = '0; a.mem_wmask = '0;
        e.mem_addr = '0; e.mem_size = '0; e.mem_wen = '0; e.mem_wdata = '0; e.mem_wmask = '0;
      end
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL vec%0d: got %h want %h", k, a, e);
      end
    end

    // Timeout: LSU byte load never answered; pulse on the 8th busy cycle with zero data.
    i_ld = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0300, 2'd0, 1'b0, 32'h0, 4'h1, 1'b0, 32'hDEAD_BEEF};
    step(i_ld);
    chk("to_grant", {bus.mem_reqValid, bus.lsu_respValid}, 2'b00);
    for (int c = 1; c <= 7; c++) begin
      step(i_ld);
      chk($sformatf("to_wait%0d", c), {bus.mem_reqValid, bus.lsu_respValid, bus.ifu_respValid, bus.err_timeout}, 4'b1000);
      if (c == 1)
        chk("to_fields", {bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wmask}, {32'h8000_0300, 2'd0, 1'b0, 4'h1});
    end
    step(i_ld);
    chk("to_fire", {bus.mem_reqValid, bus.lsu_respValid, bus.ifu_respValid, bus.err_timeout, bus.lsu_rdata}, {4'b1101, 32'h0});
    step('{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0000_0ABC});
    chk("to_late", {bus.mem_reqValid, bus.lsu_respValid, bus.ifu_respValid, bus.err_timeout, bus.lsu_rdata}, {4'b0001, 32'h0});
    step('0);
    chk("to_sticky", {bus.mem_reqValid, bus.err_timeout}, 2'b01);

    // Reset on the 2nd busy cycle of an IFU fetch; the late response must be dropped.
    i_rq = '{1'b0, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0};
    step(i_rq);
    chk("rst_idle", {bus.mem_reqValid, bus.err_timeout}, 2'b01);
    step(i_rq);
    chk("rst_busy1", {bus.mem_reqValid, bus.ifu_respValid, bus.mem_addr}, {2'b10, 32'h8000_0010});
    i_rq.rst = 1'b1;
    step(i_rq);
    chk("rst_busy2", {bus.mem_reqValid, bus.ifu_respValid}, 2'b10);
    step('{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0000_5555});
    chk("rst_after", {bus.mem_reqValid, bus.ifu_respValid, bus.lsu_respValid, bus.err_timeout, bus.ifu_rdata},
        {4'b0000, 32'h0});
    step('0);
    chk("rst_quiet", {bus.mem_reqValid, bus.ifu_respValid, bus.lsu_respValid}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
